// File: rtl/twobit_compare_sequencer_if.sv
// Requester handshake plus comparator slice bus for twobit_compare_sequencer.
interface twobit_compare_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             InStart;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic [1:0]       OutCmpA;
  logic [1:0]       OutCmpB;
  logic             InCmpGT;
  logic             InCmpEQ;
  logic             InCmpLT;
  logic             OutBusy;
  logic             OutDone;
  logic             OutGT;
  logic             OutEQ;
  logic             OutLT;
  logic             OutErr;

  // Sequencer view.
  modport slave (
    input  InStart, InA, InB, InCmpGT, InCmpEQ, InCmpLT,
    output OutCmpA, OutCmpB, OutBusy, OutDone, OutGT, OutEQ, OutLT, OutErr
  );

  // Requester/comparator environment view.
  modport master (
    output InStart, InA, InB, InCmpGT, InCmpEQ, InCmpLT,
    input  OutCmpA, OutCmpB, OutBusy, OutDone, OutGT, OutEQ, OutLT, OutErr
  );
endinterface

// File: rtl/twobit_compare_sequencer.sv
// Drives a shared 2-bit comparator slice by slice (MSB first) to compare two
// WIDTH-bit unsigned operands, stopping at the first unequal slice.
module twobit_compare_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       InClk,
  input  logic                       InRstN,
  twobit_compare_sequencer_if.slave  bus
);
  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_dn;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       cmp_a;
  logic [1:0]       cmp_b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             err;
  logic [2:0]       resp;
  logic [1:0]       slc_a [NSLICE];
  logic [1:0]       slc_b [NSLICE];

  // Split the captured operands into 2-bit slices for indexed selection.
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    assign slc_a[i] = op_a[2*i+1:2*i];
    assign slc_b[i] = op_b[2*i+1:2*i];
  end

  // Next slice index and packed comparator response.
  always_comb begin
    idx_dn = idx - IW'(1);
    resp   = {bus.InCmpGT, bus.InCmpEQ, bus.InCmpLT};
  end

  // Sequencing FSM with registered slice drive and results.
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      state <= IDLE;
      idx   <= IW'(NSLICE - 1);
      op_a  <= '0;
      op_b  <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.InStart) begin
            op_a  <= bus.InA;
            op_b  <= bus.InB;
            idx   <= IW'(NSLICE - 1);
            cmp_a <= bus.InA[WIDTH-1 -: 2];
            cmp_b <= bus.InB[WIDTH-1 -: 2];
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          case (resp)
            3'b100: begin
              gt    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
            3'b001: begin
              lt    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
            3'b010: begin
              if (idx == '0) begin
                eq    <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                idx   <= idx_dn;
                cmp_a <= slc_a[idx_dn];
                cmp_b <= slc_b[idx_dn];
              end
            end
            default: begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.OutCmpA = cmp_a;
  assign bus.OutCmpB = cmp_b;
  assign bus.OutBusy = busy;
  assign bus.OutDone = done;
  assign bus.OutGT   = gt;
  assign bus.OutEQ   = eq;
  assign bus.OutLT   = lt;
  assign bus.OutErr  = err;
endmodule

// File: tb/tb_twobit_compare_sequencer.sv
// Directed bench for twobit_compare_sequencer at WIDTH=8 and WIDTH=2.
module tb_twobit_compare_sequencer;
  logic clk;
  logic rst_n;
  logic fault;
  int   n_checks;
  int   n_fail;
  logic [7:0] seq;

  twobit_compare_sequencer_if #(.WIDTH(8)) bus8 ();
  twobit_compare_sequencer_if #(.WIDTH(2)) bus2 ();

  twobit_compare_sequencer #(.WIDTH(8)) u_dut8 (
    .InClk  (clk),
    .InRstN (rst_n),
    .bus    (bus8)
  );

  twobit_compare_sequencer #(.WIDTH(2)) u_dut2 (
    .InClk  (clk),
    .InRstN (rst_n),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2-bit comparators, with an injectable GT+LT fault on the wide one.
  always_comb begin
    bus8.InCmpGT = bus8.OutCmpA > bus8.OutCmpB;
    bus8.InCmpEQ = bus8.OutCmpA == bus8.OutCmpB;
    bus8.InCmpLT = bus8.OutCmpA < bus8.OutCmpB;
    if (fault) begin
      bus8.InCmpGT = 1'b1;
      bus8.InCmpEQ = 1'b0;
      bus8.InCmpLT = 1'b1;
    end
  end

  always_comb begin
    bus2.InCmpGT = bus2.OutCmpA > bus2.OutCmpB;
    bus2.InCmpEQ = bus2.OutCmpA == bus2.OutCmpB;
    bus2.InCmpLT = bus2.OutCmpA < bus2.OutCmpB;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] res8();
    return {bus8.OutGT, bus8.OutEQ, bus8.OutLT, bus8.OutErr};
  endfunction

  // Step until OutDone, recording the A slices seen; n = edges after the start edge.
  task automatic wait_done(output int n);
    n   = 0;
    seq = '0;
    while (!bus8.OutDone && n < 20) begin
      seq = {seq[5:0], bus8.OutCmpA};
      step();
      n++;
    end
  endtask

  // One request; exp = {gt,eq,lt,err}; exp_cyc = cycle in which OutDone is high.
  task automatic run_req(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] exp, input int exp_cyc);
    int n;
    bus8.InStart = 1'b1;
    bus8.InA     = a;
    bus8.InB     = b;
    step();
    bus8.InStart = 1'b0;
    wait_done(n);
    check({tag, "_done_cycle"}, 32'(n + 1), 32'(exp_cyc));
    check({tag, "_result"}, 32'(res8()), 32'(exp));
    check({tag, "_busy_in_done"}, 32'(bus8.OutBusy), 32'd1);
    step();
    check({tag, "_done_pulse"}, 32'(bus8.OutDone), 32'd0);
    check({tag, "_idle"}, 32'(bus8.OutBusy), 32'd0);
    check({tag, "_hold"}, 32'(res8()), 32'(exp));
  endtask

  initial begin
    int n;
    int gap;
    int idles;
    logic [1:0] a2;
    logic [1:0] b2;
    logic [2:0] exp2;
    n_checks     = 0;
    n_fail       = 0;
    fault        = 1'b0;
    seq          = '0;
    bus8.InStart = 1'b0;
    bus8.InA     = '0;
    bus8.InB     = '0;
    bus2.InStart = 1'b0;
    bus2.InA     = '0;
    bus2.InB     = '0;
    rst_n        = 1'b0;
    #12;
    check("reset_outputs", 32'({bus8.OutBusy, bus8.OutDone, res8()}), 32'd0);
    check("reset_cmp", 32'({bus8.OutCmpA, bus8.OutCmpB}), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1. Reset mid-sequence aborts without OutDone.
    bus8.InStart = 1'b1;
    bus8.InA     = 8'h00;
    bus8.InB     = 8'h00;
    step();
    bus8.InStart = 1'b0;
    step();
    check("abort_busy_before", 32'(bus8.OutBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({bus8.OutBusy, bus8.OutDone, res8()}), 32'd0);
    check("abort_cmp", 32'({bus8.OutCmpA, bus8.OutCmpB}), 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus8.OutDone) n++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus8.OutDone || bus8.OutBusy) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    run_req("after_reset_eq", 8'h5A, 8'h5A, 4'b0100, 5);

    // 2. Equal operands, worst case; slice sequence 2,3,1,0.
    run_req("equal_b4", 8'hB4, 8'hB4, 4'b0100, 5);
    bus8.InStart = 1'b1;
    bus8.InA     = 8'hB4;
    bus8.InB     = 8'hB4;
    step();
    bus8.InStart = 1'b0;
    wait_done(n);
    check("equal_b4_slices", 32'(seq), 32'h0000_00B4);
    step();

    // 3. MSB slice differs.
    run_req("msb_gt", 8'hC0, 8'h40, 4'b1000, 2);

    // 4. LSB slice differs.
    run_req("lsb_lt", 8'h12, 8'h13, 4'b0010, 5);

    // 5. Start ignored while busy.
    bus8.InStart = 1'b1;
    bus8.InA     = 8'h12;
    bus8.InB     = 8'h13;
    step();
    bus8.InStart = 1'b1;
    bus8.InA     = 8'hFF;
    bus8.InB     = 8'h00;
    step();
    bus8.InStart = 1'b0;
    wait_done(n);
    check("busy_ignore_cycle", 32'(n + 2), 32'd5);
    check("busy_ignore_result", 32'(res8()), 32'b0010);
    step();
    step();
    check("busy_ignore_no_restart", 32'(bus8.OutBusy), 32'd0);

    // 5b. Start held high: one IDLE cycle between OutDone pulses.
    bus8.InStart = 1'b1;
    bus8.InA     = 8'hC0;
    bus8.InB     = 8'h40;
    step();
    wait_done(n);
    check("b2b_first_cycle", 32'(n + 1), 32'd2);
    gap   = 0;
    idles = 0;
    step();
    gap++;
    while (!bus8.OutDone && gap < 20) begin
      if (!bus8.OutBusy) idles++;
      step();
      gap++;
    end
    bus8.InStart = 1'b0;
    check("b2b_gap_edges", 32'(gap), 32'd3);
    check("b2b_idle_cycles", 32'(idles), 32'd1);
    check("b2b_second_result", 32'(res8()), 32'b1000);
    step();
    step();
    check("b2b_stopped", 32'(bus8.OutBusy), 32'd0);

    // 6. Faulty comparator response.
    fault = 1'b1;
    run_req("fault_gt_lt", 8'h33, 8'h33, 4'b0001, 2);
    fault = 1'b0;
    run_req("fault_cleared", 8'h00, 8'h01, 4'b0010, 5);

    // 6b. Exhaustive WIDTH=2.
    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i >> 2);
      b2 = 2'(i);
      exp2 = (a2 > b2) ? 3'b100 : (a2 == b2) ? 3'b010 : 3'b001;
      bus2.InStart = 1'b1;
      bus2.InA     = a2;
      bus2.InB     = b2;
      step();
      bus2.InStart = 1'b0;
      step();
      check($sformatf("w2_done_%0d_%0d", a2, b2), 32'(bus2.OutDone), 32'd1);
      check($sformatf("w2_res_%0d_%0d", a2, b2),
            32'({bus2.OutGT, bus2.OutEQ, bus2.OutLT, bus2.OutErr}), 32'({exp2, 1'b0}));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/twobit_compare_sequencer.md
Name: twobit_compare_sequencer

Overview:
- Sequences an external combinational 2-bit magnitude comparator to compare two WIDTH-bit unsigned operands.
- Feeds the operand slices to the comparator two bits at a time, most significant slice first, and stops at the first unequal slice.
- Sits between a requester (start/done handshake) and one shared twobit_comparator instance; the comparator's InA/InB are driven from OutCmpA and its InC/InD from OutCmpB.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; NSLICE = WIDTH/2.

Ports:
InClk  input  1  clock, rising edge.
InRstN  input  1  reset, asynchronous, active-low.
InStart  input  1  start request; sampled only in IDLE.
InA  input  WIDTH  operand A; captured on an accepted start.
InB  input  WIDTH  operand B; captured on an accepted start.
OutCmpA  output  2  current A slice to comparator (bit1 -> InA, bit0 -> InB).
OutCmpB  output  2  current B slice to comparator (bit1 -> InC, bit0 -> InD).
InCmpGT  input  1  comparator OutF1: slice A > slice B.
InCmpEQ  input  1  comparator OutF2: slice A == slice B.
InCmpLT  input  1  comparator OutF3: slice A < slice B.
OutBusy  output  1  high in COMPARE and DONE.
OutDone  output  1  one-cycle pulse; result valid.
OutGT  output  1  registered result: A > B.
OutEQ  output  1  registered result: A == B.
OutLT  output  1  registered result: A < B.
OutErr  output  1  registered: comparator returned a non-one-hot response.

Behaviour:
- Reset (InRstN low, asynchronous): state = IDLE; slice index = NSLICE-1; captured operands = 0; OutCmpA/OutCmpB = 0; OutBusy, OutDone, OutGT, OutEQ, OutLT, OutErr = 0.
- Reset asserted mid-operation aborts the compare immediately. No OutDone is produced for the aborted request.
- FSM states:
  - IDLE: InStart=1 at an edge -> capture InA/InB, index = NSLICE-1, clear OutGT/OutEQ/OutLT/OutErr, go to COMPARE.
  - COMPARE: OutCmpA = A[2*idx+1 : 2*idx], OutCmpB = B[2*idx+1 : 2*idx], registered from the captured operands and index. Comparator inputs are sampled at each edge:
    - exactly GT -> OutGT=1, go to DONE;
    - exactly LT -> OutLT=1, go to DONE;
    - exactly EQ and idx>0 -> idx decrements, stay in COMPARE;
    - exactly EQ and idx==0 -> OutEQ=1, go to DONE;
    - zero or more than one of GT/EQ/LT asserted -> OutErr=1 with GT/EQ/LT = 0, go to DONE.
  - DONE: OutDone=1 for this single cycle, then IDLE unconditionally.
- Latency: start accepted at edge 0. Slice k (counted from MSB, k = 1..NSLICE) is evaluated at edge k, and OutDone is high during the cycle after that edge.
  - Worst case (all equal): OutDone high in cycle NSLICE+1; total NSLICE+2 cycles from start to back in IDLE.
  - Best case (MSB slice differs): OutDone in cycle 2.
- OutGT/OutEQ/OutLT/OutErr hold their value after DONE until the next accepted start clears them. Exactly one of the four is 1 after any completed request.
- InStart is ignored in COMPARE and DONE; there is no queuing. InStart held high continuously restarts in the first IDLE cycle after DONE, using InA/InB sampled at that edge.
- InA/InB changes after capture do not affect the request in flight.
- OutCmpA/OutCmpB hold their last slice outside COMPARE. The comparator result is don't-care there.
- WIDTH=2: a single compare cycle, so OutDone occurs in cycle 2 always.

Test Plan:
Bench setup: WIDTH=8 with a behavioural twobit_comparator model.
1. Reset mid-sequence: A=8'h00, B=8'h00, InStart, then InRstN low at cycle 2 -> all outputs 0 immediately, state IDLE, no OutDone; after release a new start with A=8'h5A, B=8'h5A completes OutEQ=1.
2. Equal operands, worst-case latency: A=8'hB4, B=8'hB4 -> OutCmpA sequence 2,3,1,0; OutDone high in cycle 5; OutEQ=1, OutGT=OutLT=OutErr=0.
3. Early termination, MSB slice: A=8'hC0, B=8'h40 -> one compare cycle; OutDone in cycle 2; OutGT=1.
4. Late termination, LSB slice: A=8'h12, B=8'h13 -> four compare cycles; OutLT=1; OutDone in cycle 5.
5. Start ignored while busy: a second InStart pulse with A=8'hFF, B=8'h00 during COMPARE -> ignored, first result unchanged. Then InStart held high -> back-to-back requests with exactly one IDLE cycle between OutDone pulses.
6. Faulty comparator: force InCmpGT=InCmpLT=1 on the first slice -> OutErr=1, GT/EQ/LT=0, OutDone in cycle 2. Then exhaustive 2-bit check at WIDTH=2 (all 16 A/B pairs) -> results match A>B / A==B / A<B.
